// File: rtl/clk_divider.sv
// Three independent half-period dividers producing clk_core, clkI2C and clkUART
// from one system clock; every output comes straight from a toggle flop.
module clk_divider #(
    parameter int unsigned CORE_HALF     = 1,
    parameter int unsigned I2C_HALF_STD  = 83,
    parameter int unsigned I2C_HALF_FAST = 21,
    parameter int unsigned UART_HALF_0   = 868,
    parameter int unsigned UART_HALF_1   = 434,
    parameter int unsigned UART_HALF_2   = 145,
    parameter int unsigned UART_HALF_3   = 72
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkI2Csel,
    input  logic [1:0] clkUARTsel,
    output logic       clk_core,
    output logic       clkI2C,
    output logic       clkUART
);

    // A half-period of 0 behaves as 1, so the terminal count saturates at 0.
    function automatic logic [15:0] term_of(input int unsigned half);
        if (half == 0) return 16'd0;
        return 16'(half - 1);
    endfunction

    localparam logic [15:0] CORE_T   = term_of(CORE_HALF);
    localparam logic [15:0] I2C_T_S  = term_of(I2C_HALF_STD);
    localparam logic [15:0] I2C_T_F  = term_of(I2C_HALF_FAST);
    localparam logic [15:0] UART_T_0 = term_of(UART_HALF_0);
    localparam logic [15:0] UART_T_1 = term_of(UART_HALF_1);
    localparam logic [15:0] UART_T_2 = term_of(UART_HALF_2);
    localparam logic [15:0] UART_T_3 = term_of(UART_HALF_3);

    logic [15:0] r_core_cnt;
    logic [15:0] r_i2c_cnt;
    logic [15:0] r_uart_cnt;
    logic        r_core_q;
    logic        r_i2c_q;
    logic        r_uart_q;
    logic [15:0] w_i2c_term;
    logic [15:0] w_uart_term;

    always_comb begin
        w_i2c_term = clkI2Csel ? I2C_T_F : I2C_T_S;
    end

    always_comb begin
        w_uart_term = UART_T_0;
        case (clkUARTsel)
            2'b00:   w_uart_term = UART_T_0;
            2'b01:   w_uart_term = UART_T_1;
            2'b10:   w_uart_term = UART_T_2;
            default: w_uart_term = UART_T_3;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_core_cnt <= '0;
            r_core_q   <= 1'b0;
        end else if (r_core_cnt >= CORE_T) begin
            r_core_cnt <= '0;
            r_core_q   <= ~r_core_q;
        end else begin
            r_core_cnt <= r_core_cnt + 16'd1;
        end
    end

    // >= rather than == lets a switch to a shorter rate terminate at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i2c_cnt <= '0;
            r_i2c_q   <= 1'b0;
        end else if (r_i2c_cnt >= w_i2c_term) begin
            r_i2c_cnt <= '0;
            r_i2c_q   <= ~r_i2c_q;
        end else begin
            r_i2c_cnt <= r_i2c_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_uart_cnt <= '0;
            r_uart_q   <= 1'b0;
        end else if (r_uart_cnt >= w_uart_term) begin
            r_uart_cnt <= '0;
            r_uart_q   <= ~r_uart_q;
        end else begin
            r_uart_cnt <= r_uart_cnt + 16'd1;
        end
    end

    assign clk_core = r_core_q;
    assign clkI2C   = r_i2c_q;
    assign clkUART  = r_uart_q;

endmodule

// File: tb/tb_clk_divider.sv
// Directed bench for clk_divider: phase lengths, rate switching, async reset
// and zero-valued half-period parameters.
module tb_clk_divider;

    localparam int LIM = 4000;

    logic       clk;
    logic       reset;
    logic       clkI2Csel;
    logic [1:0] clkUARTsel;
    logic       clk_core, clkI2C, clkUART;
    logic       z_core, z_i2c, z_uart;

    int n_vec = 0;
    int n_err = 0;

    clk_divider dut (
        .clk        (clk),
        .reset      (reset),
        .clkI2Csel  (clkI2Csel),
        .clkUARTsel (clkUARTsel),
        .clk_core   (clk_core),
        .clkI2C     (clkI2C),
        .clkUART    (clkUART)
    );

    clk_divider #(
        .CORE_HALF     (0),
        .I2C_HALF_STD  (0),
        .I2C_HALF_FAST (0),
        .UART_HALF_0   (0),
        .UART_HALF_1   (0),
        .UART_HALF_2   (0),
        .UART_HALF_3   (0)
    ) dut_zero (
        .clk        (clk),
        .reset      (reset),
        .clkI2Csel  (clkI2Csel),
        .clkUARTsel (clkUARTsel),
        .clk_core   (z_core),
        .clkI2C     (z_i2c),
        .clkUART    (z_uart)
    );

    initial clk = 1'b0;
    always #30 clk = ~clk;

    function automatic logic pick(input int which);
        case (which)
            0:       return clk_core;
            1:       return clkI2C;
            default: return clkUART;
        endcase
    endfunction

    // Syncs to the next rising edge of an output, then counts high and low phases in clks.
    task automatic measure(input int which, output int hi, output int lo);
        int n;
        n = 0;
        while (pick(which) !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
        n = 0;
        while (pick(which) !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        hi = 0;
        while (pick(which) === 1'b1 && hi < LIM) begin @(negedge clk); hi++; end
        lo = 0;
        while (pick(which) === 1'b0 && lo < LIM) begin @(negedge clk); lo++; end
    endtask

    task automatic test_reset;
        reset      = 1'b0;
        clkI2Csel  = 1'b0;
        clkUARTsel = 2'b00;
        #5;
        n_vec++;
        if ({clk_core, clkI2C, clkUART} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs got=%b exp=000", {clk_core, clkI2C, clkUART});
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({clk_core, clkI2C, clkUART} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_held got=%b exp=000", {clk_core, clkI2C, clkUART});
        end
    endtask

    task automatic test_first_edges;
        reset = 1'b1;
        for (int e = 1; e <= 868; e++) begin
            @(negedge clk);
            if (e == 1) begin
                n_vec++;
                if (clk_core !== 1'b1) begin
                    n_err++;
                    $display("FAIL first_core got=%b exp=1", clk_core);
                end
            end
            if (e == 82 || e == 83) begin
                n_vec++;
                if (clkI2C !== (e == 83)) begin
                    n_err++;
                    $display("FAIL first_i2c edge=%0d got=%b exp=%b", e, clkI2C, e == 83);
                end
            end
            if (e == 867 || e == 868) begin
                n_vec++;
                if (clkUART !== (e == 868)) begin
                    n_err++;
                    $display("FAIL first_uart edge=%0d got=%b exp=%b", e, clkUART, e == 868);
                end
            end
        end
    endtask

    task automatic test_core;
        int hi, lo;
        measure(0, hi, lo);
        n_vec++;
        if (hi !== 1 || lo !== 1) begin
            n_err++;
            $display("FAIL core_period hi=%0d lo=%0d exp=1/1", hi, lo);
        end
    endtask

    task automatic test_i2c;
        int hi, lo;
        int exp_h [2] = '{83, 21};
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            clkI2Csel = s[0];
            measure(1, hi, lo);
            n_vec++;
            if (hi !== exp_h[s] || lo !== exp_h[s]) begin
                n_err++;
                $display("FAIL i2c_sel%0d hi=%0d lo=%0d exp=%0d", s, hi, lo, exp_h[s]);
            end
        end
        @(negedge clk);
        clkI2Csel = 1'b0;
    endtask

    task automatic test_uart;
        int hi, lo;
        int exp_h [4] = '{868, 434, 145, 72};
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            clkUARTsel = 2'(s);
            measure(2, hi, lo);
            n_vec++;
            if (hi !== exp_h[s] || lo !== exp_h[s]) begin
                n_err++;
                $display("FAIL uart_sel%0d hi=%0d lo=%0d exp=%0d", s, hi, lo, exp_h[s]);
            end
            measure(0, hi, lo);
            n_vec++;
            if (hi !== 1 || lo !== 1) begin
                n_err++;
                $display("FAIL core_during_uart%0d hi=%0d lo=%0d exp=1/1", s, hi, lo);
            end
        end
    endtask

    task automatic test_switch_down;
        int hi, lo, n;
        @(negedge clk);
        clkUARTsel = 2'b00;
        measure(2, hi, lo);
        measure(2, hi, lo);
        // clkUART just rose: counter is 0 here, 500 after 500 more edges.
        repeat (500) @(negedge clk);
        clkUARTsel = 2'b11;
        @(negedge clk);
        n_vec++;
        if (clkUART !== 1'b0) begin
            n_err++;
            $display("FAIL switch_toggle got=%b exp=0", clkUART);
        end
        n = 0;
        while (clkUART === 1'b0 && n < LIM) begin @(negedge clk); n++; end
        n_vec++;
        if (n !== 72) begin
            n_err++;
            $display("FAIL switch_low got=%0d exp=72", n);
        end
        n = 0;
        while (clkUART === 1'b1 && n < LIM) begin @(negedge clk); n++; end
        n_vec++;
        if (n !== 72) begin
            n_err++;
            $display("FAIL switch_high got=%0d exp=72", n);
        end
    endtask

    task automatic test_async_reset;
        int hi, lo;
        @(negedge clk);
        clkI2Csel = 1'b0;
        measure(1, hi, lo);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #10 reset = 1'b0;
        #1;
        n_vec++;
        if ({clk_core, clkI2C, clkUART} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset got=%b exp=000", {clk_core, clkI2C, clkUART});
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if ({clk_core, clkI2C, clkUART} !== 3'b000) begin
            n_err++;
            $display("FAIL async_held got=%b exp=000", {clk_core, clkI2C, clkUART});
        end
        reset = 1'b1;
        for (int e = 1; e <= 83; e++) begin
            @(negedge clk);
            if (e == 1) begin
                n_vec++;
                if (clk_core !== 1'b1) begin
                    n_err++;
                    $display("FAIL rel_core got=%b exp=1", clk_core);
                end
            end
            if (e == 82 || e == 83) begin
                n_vec++;
                if (clkI2C !== (e == 83)) begin
                    n_err++;
                    $display("FAIL rel_i2c edge=%0d got=%b exp=%b", e, clkI2C, e == 83);
                end
            end
        end
    endtask

    task automatic test_zero_param;
        logic [2:0] prev;
        @(negedge clk);
        prev = {z_core, z_i2c, z_uart};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if ({z_core, z_i2c, z_uart} !== ~prev || prev[0] !== prev[2] || prev[1] !== prev[2]) begin
                n_err++;
                $display("FAIL zero_param got=%b exp=%b", {z_core, z_i2c, z_uart}, ~prev);
            end
            prev = {z_core, z_i2c, z_uart};
        end
    endtask

    initial begin
        test_reset;
        test_first_edges;
        test_core;
        test_i2c;
        test_uart;
        test_switch_down;
        test_async_reset;
        test_zero_param;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
